counter_nbits: RTL
==================

# counter_nbits

Parametrised synchronous modulo-N up/down counter with enable, synchronous clear, terminal-count flag and registered wrap pulse. It is the general-purpose counter primitive for clock dividers, display scan and timing chains, and replaces fixed-width ripple counters. All flops share one clock edge, so outputs are glitch-free and cascadable through `tc`.

## Interface

Parameters:
- `WIDTH`, default 2: counter width in bits; legal range 1..32.
- `MODULUS`, default `2**WIDTH`: count length; legal range 2..`2**WIDTH`; `MAX = MODULUS-1`.

Ports:
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst_n`  in  1  reset; asynchronous, active-low.
- `en`  in  1  count enable.
- `up`  in  1  direction; 1 counts up, 0 counts down.
- `clr`  in  1  synchronous clear to 0.
- `load`  in  1  synchronous parallel load; present only with `COUNTER_LOAD_EN`.
- `din`  in  WIDTH  load value; present only with `COUNTER_LOAD_EN`.
- `A`  out  WIDTH  current count.
- `Qn`  out  WIDTH  bitwise complement of `A`.
- `tc`  out  1  terminal count, combinational.
- `wrap`  out  1  registered one-cycle pulse marking a wrap.

## Operation

- Reset (`rst_n`=0, asynchronous): `A`=0, `Qn`=all ones, `wrap`=0. `tc` then equals `~up`.
- The next-state priority per rising edge is `clr` > `load` > `en` > hold.
- `clr`=1: `A`←0. `wrap`←0.
- `load`=1: `A`←`din` when `din`≤`MAX`, otherwise `A`←`MAX` (saturated). `wrap`←0.
- `en`=1 with `up`=1: `A`←`A+1`. When `A`==`MAX`, `A`←0 and `wrap`←1.
- `en`=1 with `up`=0: `A`←`A-1`. When `A`==0, `A`←`MAX` and `wrap`←1.
- `en`=0: `A` holds and `wrap`←0.
- `wrap` is 1 only in the cycle immediately after a wrapping edge.
- `tc` = (`up` ? `A`==`MAX` : `A`==0). It does not depend on `en`, so the next stage enables with `en & tc`.
- Arithmetic is done modulo `MODULUS`. Intermediate sums are at least WIDTH+1 bits wide so that no truncation occurs when `MODULUS`=`2**WIDTH`.
- Changing direction mid-count takes effect on the next edge and does not disturb `A`.
- Reset asserted mid-count forces the reset values immediately, regardless of `clk`. Release is synchronised externally.

## Timing

- The latency from `en`, `clr` or `load` to the change in `A` is 1 cycle.
- `Qn` is combinational from `A`. It has zero added latency and is never out of step with `A`.
- `tc` is combinational from `A`, `up` and the parameters. Its depth is one WIDTH-bit comparator.
- `wrap` is asserted on the same edge on which `A` wraps, and is visible in the cycle after the terminal count.
- There are no multicycle paths. The design targets one WIDTH=32 increment per cycle.

## Configuration

- `COUNTER_LOAD_EN` defined: the `load` and `din` ports exist and follow the load rules above.
- `COUNTER_LOAD_EN` undefined: the `load` and `din` ports are absent and there is no load path. Priority becomes `clr` > `en` > hold. All other behaviour is identical.

## Structure

- Shared package `counter_pkg`:
  - Direction constants `CNT_DOWN`=1'b0 and `CNT_UP`=1'b1.
  - A `clog2`-style helper function used for parameter checks.
- Parameter legality is checked at elaboration. An illegal `MODULUS` or `WIDTH` is a fatal error.
- Sub-module `counter_next`: purely combinational. It takes `A`, `up` and `MAX` and produces the next value and the wrap condition. The top level holds the registers, the priority mux and the `wrap` flop.

## Test plan

- Reset and up-count, WIDTH=2 default: hold `rst_n` low → `A`=0, `Qn`=3, `wrap`=0. Release with `en`=1, `up`=1 → `A` goes 1,2,3,0. `wrap`=1 only in the cycle where `A`=0 after the 3. `tc`=1 while `A`=3.
- Modulo-10 down-count, WIDTH=4, MODULUS=10: from `A`=0 with `up`=0, `en`=1 → `A`=9,8,…,0,9. `wrap` pulses after 0→9. `tc`=1 at `A`=0.
- Priority and saturation, `COUNTER_LOAD_EN`, MODULUS=10: `clr`=1, `load`=1, `din`=5 in the same cycle → `A`=0. Next cycle `load`=1, `din`=12 → `A`=9. Next cycle `en`=0 → `A` holds at 9 and `wrap`=0.
- Direction change and hold: count up to 2, then toggle `up`=0 → `A`=1. Then `en`=0 for 3 cycles → `A` stays at 1 and `tc` follows `up` only.
- Asynchronous reset mid-count, WIDTH=8: at `A`=0x7F, pulse `rst_n` low between clock edges → `A`=0 and `Qn`=0xFF immediately, with no clock edge needed.
- Cascade, two WIDTH=4 MODULUS=10 instances with the upper `en` = lower `tc`: after 100 enables → both instances read 0, the upper `wrap` pulses once, and the lower `wrap` pulses 10 times.

Source files
------------

// File: rtl/counter_pkg.sv
// Shared constants and helpers for the modulo-N counter family.
// Direction encodings and a ceil-log2 used for parameter legality checks.
package counter_pkg;

    typedef enum logic {
        CNT_DOWN = 1'b0,
        CNT_UP   = 1'b1
    } cnt_dir_e;

    localparam int unsigned CNT_MAX_WIDTH = 32;

    // Smallest r with 2**r >= v; constant-foldable for elaboration checks.
    function automatic int unsigned clog2(input longint unsigned v);
        int unsigned r;
        r = 0;
        for (int i = 0; i < 63; i++) begin
            if ((64'd1 << i) < v) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/counter_next.sv
// Combinational next-count and wrap detection for counter_nbits.
// Up path uses a WIDTH+1 bit sum so MODULUS = 2**WIDTH never truncates.
module counter_next
    import counter_pkg::*;
#(
    parameter int unsigned WIDTH = 2
) (
    input  logic [WIDTH-1:0] i_a,
    input  logic             i_up,
    input  logic [WIDTH-1:0] i_max,
    output logic [WIDTH-1:0] o_nxt,
    output logic             o_wrap
);

    logic [WIDTH:0]   w_inc;
    logic [WIDTH:0]   w_mod;
    logic [WIDTH-1:0] w_dec;
    logic             w_wrap_up;
    logic             w_wrap_dn;

    assign w_inc     = {1'b0, i_a} + (WIDTH+1)'(1);
    assign w_mod     = {1'b0, i_max} + (WIDTH+1)'(1);
    assign w_dec     = i_a - WIDTH'(1);
    assign w_wrap_up = (w_inc == w_mod);
    assign w_wrap_dn = (i_a == '0);

    always_comb begin
        o_nxt  = i_a;
        o_wrap = 1'b0;
        if (i_up == CNT_UP) begin
            o_wrap = w_wrap_up;
            o_nxt  = w_wrap_up ? '0 : w_inc[WIDTH-1:0];
        end else if (i_up == CNT_DOWN) begin
            o_wrap = w_wrap_dn;
            o_nxt  = w_wrap_dn ? i_max : w_dec;
        end
    end

endmodule

// File: rtl/counter_nbits.sv
// Modulo-N up/down counter with clear, terminal count and registered wrap.
// Define COUNTER_LOAD_EN to add the saturating parallel load (load/din).
module counter_nbits
    import counter_pkg::*;
#(
    parameter int unsigned     WIDTH   = 2,
    parameter longint unsigned MODULUS = 64'd1 << WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             up,
    input  logic             clr,
`ifdef COUNTER_LOAD_EN
    input  logic             load,
    input  logic [WIDTH-1:0] din,
`endif
    output logic [WIDTH-1:0] A,
    output logic [WIDTH-1:0] Qn,
    output logic             tc,
    output logic             wrap
);

    localparam logic [WIDTH-1:0] MAX = WIDTH'(MODULUS - 64'd1);

    if (WIDTH < 1 || WIDTH > CNT_MAX_WIDTH) begin : g_bad_width
        $fatal(1, "counter_nbits: WIDTH out of range 1..32");
    end

    if (MODULUS < 2 || clog2(MODULUS) > WIDTH) begin : g_bad_mod
        $fatal(1, "counter_nbits: MODULUS out of range 2..2**WIDTH");
    end

    logic [WIDTH-1:0] r_a;
    logic             r_wrap;
    logic [WIDTH-1:0] w_nxt;
    logic             w_wrap;

    counter_next #(
        .WIDTH (WIDTH)
    ) u_next (
        .i_a    (r_a),
        .i_up   (up),
        .i_max  (MAX),
        .o_nxt  (w_nxt),
        .o_wrap (w_wrap)
    );

`ifdef COUNTER_LOAD_EN
    logic [WIDTH-1:0] w_load_val;

    assign w_load_val = (din > MAX) ? MAX : din;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a    <= '0;
            r_wrap <= 1'b0;
        end else if (clr) begin
            r_a    <= '0;
            r_wrap <= 1'b0;
`ifdef COUNTER_LOAD_EN
        end else if (load) begin
            r_a    <= w_load_val;
            r_wrap <= 1'b0;
`endif
        end else if (en) begin
            r_a    <= w_nxt;
            r_wrap <= w_wrap;
        end else begin
            r_wrap <= 1'b0;
        end
    end

    assign A    = r_a;
    assign Qn   = ~r_a;
    assign wrap = r_wrap;
    assign tc   = (up == CNT_UP) ? (r_a == MAX) : (r_a == '0);

endmodule
